irq_arbiter: RTL

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-captured interrupt arbiter with mask, ack timeout and IDLE/PEND/SERV handshake.
// Define IRQ_PRIORITY_ROTATE_EN for round-robin selection; the default is fixed lowest-index-first.
module irq_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               IRQ,
  output logic [3:0]         irq_id,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_flag
);
  typedef enum logic [1:0] {IDLE, PEND, SERV} state_t;
  state_t r_state, w_next;
  logic [NUM_SRC-1:0] r_prev, r_pend, r_mask, w_edge, w_elig, w_clr;
  logic [3:0] r_id, w_sel;
  logic [15:0] r_cnt;
  logic r_to, w_ack, w_timeout;
  assign w_edge    = irq_src & ~r_prev;
  assign w_elig    = r_pend & r_mask;
  assign w_ack     = (r_state == PEND) && irq_ack;
  assign w_timeout = (r_state == PEND) && !irq_ack && (r_cnt == 16'(ACK_TIMEOUT - 1));
  assign w_clr     = w_ack ? (NUM_SRC'(1) << r_id) : '0;
  assign IRQ          = (r_state == PEND);
  assign irq_id       = r_id;
  assign pending      = r_pend;
  assign timeout_flag = r_to;
`ifdef IRQ_PRIORITY_ROTATE_EN
  logic [3:0] r_last;
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) r_last <= 4'(NUM_SRC - 1);
    else if (w_ack) r_last <= r_id;
  // Descending scan so the first eligible source after r_last is the one kept
  always_comb begin
    w_sel = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (w_elig[(int'(r_last) + 1 + k) % NUM_SRC]) w_sel = 4'((int'(r_last) + 1 + k) % NUM_SRC);
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (w_elig[i]) w_sel = 4'(i);
  end
`endif
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |w_elig ? PEND : IDLE;
      PEND:    w_next = irq_ack ? SERV : (w_timeout ? IDLE : PEND);
      SERV:    w_next = irq_done ? IDLE : SERV;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      r_prev <= '0;
      r_pend <= '0;
      r_mask <= '1;
      r_id   <= '0;
      r_cnt  <= '0;
      r_to   <= 1'b0;
    end else begin
      r_prev <= irq_src;
      r_pend <= (r_pend & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
      if (r_state == IDLE && |w_elig) r_id <= w_sel;
      r_cnt  <= (r_state == PEND) ? r_cnt + 16'd1 : '0;
      if (w_timeout) r_to <= 1'b1;
    end
endmodule
